// File: rtl/ram_arb_pkg.sv
// Shared types for the two-master RAM arbiter: arbitration state and owner id.
package ram_arb_pkg;

   typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_t;
   typedef enum logic {M0, M1} owner_t;

endpackage

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one synchronous single-port RAM between two masters,
// with a bounded hold per grant and a one-cycle registered read-valid return.
module ram_arbiter
   import ram_arb_pkg::*;
#(
   parameter int DATA_W   = 9,
   parameter int ADDR_W   = 9,
   parameter int MAX_HOLD = 4
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_gnt,
   output logic              m0_rvalid,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_gnt,
   output logic              m1_rvalid,
   output logic [DATA_W-1:0] rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              ram_we,
   input  logic [DATA_W-1:0] ram_rdata
);

   localparam int              HC_W      = $clog2(MAX_HOLD + 1);
   localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(MAX_HOLD - 1);

   arb_state_t        r_state;
   owner_t            r_last_owner;
   logic [HC_W-1:0]   r_hold_cnt;
   logic              r_m0_rvalid_p1;
   logic              r_m1_rvalid_p1;

   logic              w_own_req;
   logic              w_own_we;
   logic              w_oth_req;
   logic [ADDR_W-1:0] w_own_addr;
   logic [DATA_W-1:0] w_own_wdata;

   assign m0_gnt = (r_state == OWN0);
   assign m1_gnt = (r_state == OWN1);

   // Owner mux: with no owner every field stays zero, so nothing reaches the RAM.
   always_comb begin
      w_own_req   = 1'b0;
      w_own_we    = 1'b0;
      w_oth_req   = 1'b0;
      w_own_addr  = '0;
      w_own_wdata = '0;
      case (r_state)
         OWN0: begin
            w_own_req   = m0_req;
            w_own_we    = m0_we;
            w_own_addr  = m0_addr;
            w_own_wdata = m0_wdata;
            w_oth_req   = m1_req;
         end
         OWN1: begin
            w_own_req   = m1_req;
            w_own_we    = m1_we;
            w_own_addr  = m1_addr;
            w_own_wdata = m1_wdata;
            w_oth_req   = m0_req;
         end
         default: ;
      endcase
   end

   assign ram_we    = w_own_req & w_own_we;
   assign ram_addr  = w_own_req ? w_own_addr  : '0;
   assign ram_wdata = w_own_req ? w_own_wdata : '0;
   assign rdata     = ram_rdata;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= IDLE;
         r_last_owner <= M1;
         r_hold_cnt   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               r_hold_cnt <= '0;
               if (m0_req && (!m1_req || r_last_owner == M1)) begin
                  r_state      <= OWN0;
                  r_last_owner <= M0;
               end else if (m1_req) begin
                  r_state      <= OWN1;
                  r_last_owner <= M1;
               end
            end
            OWN0, OWN1: begin
               // Release on owner idle, or on the last allowed transfer while the other waits.
               if (!w_own_req || (r_hold_cnt == HOLD_LAST && w_oth_req)) begin
                  r_hold_cnt <= '0;
                  if (w_oth_req) begin
                     r_state      <= (r_state == OWN0) ? OWN1 : OWN0;
                     r_last_owner <= (r_state == OWN0) ? M1 : M0;
                  end else begin
                     r_state <= IDLE;
                  end
               end else if (r_hold_cnt != HOLD_LAST) begin
                  r_hold_cnt <= r_hold_cnt + 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Read return: valid follows the master that issued the read, even across a switch.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_m0_rvalid_p1 <= 1'b0;
         r_m1_rvalid_p1 <= 1'b0;
      end else begin
         r_m0_rvalid_p1 <= m0_gnt & m0_req & ~m0_we;
         r_m1_rvalid_p1 <= m1_gnt & m1_req & ~m1_we;
      end
   end

   assign m0_rvalid = r_m0_rvalid_p1;
   assign m1_rvalid = r_m1_rvalid_p1;

endmodule
